// File: rtl/gps_iq_readout_sched.sv
// Round-robin readout scheduler: serialises channel IQ frames into 16-bit words in an FWFT FIFO.
// Optional sticky overrun flags are enabled with `define GPS_READOUT_OVR_EN.
module gps_iq_readout_sched #(
    parameter int NCHANS     = 12,
    parameter int SER_BITS   = 108,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NCHANS-1:0]             epoch,
    input  logic [NCHANS-1:0]             sout,
    output logic [NCHANS-1:0]             shift,
    input  logic                          rd,
    output logic [15:0]                   rdata,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          busy
`ifdef GPS_READOUT_OVR_EN
    ,
    output logic [NCHANS-1:0]             ovr,
    input  logic [NCHANS-1:0]             ovr_clr
`endif
);

    localparam int CW   = (NCHANS > 1) ? $clog2(NCHANS) : 1;
    localparam int BW   = $clog2(SER_BITS + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam logic [CNTW-1:0] DEPTH_C = CNTW'(FIFO_DEPTH);
    localparam logic [BW-1:0]   LAST_C  = BW'(SER_BITS - 1);
    localparam logic [CW-1:0]   MAXCH_C = CW'(NCHANS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HDR   = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    logic [1:0]        state_r;
    logic [NCHANS-1:0] pending_r;
    logic [CW-1:0]     chan_r;
    logic [CW-1:0]     rr_r;
    logic [BW-1:0]     bitcnt_r;
    logic [3:0]        wcnt_r;
    logic [14:0]       wbuf_r;
    logic [15:0]       mem_r [FIFO_DEPTH];
    logic [AW-1:0]     wptr_r;
    logic [AW-1:0]     rptr_r;
    logic [CNTW-1:0]   count_r;

    logic              grant_found_s;
    logic [CW-1:0]     grant_idx_s;
    logic              grant_s;
    logic [NCHANS-1:0] clr_s;
    logic              full_s;
    logic              pop_s;
    logic              can_push_s;
    logic              cur_sout_s;
    logic [15:0]       cur_word_s;
    logic              abort_s;
    logic              last_s;
    logic              word_done_s;
    logic              cap_s;
    logic              push_hdr_s;
    logic              push_s;
    logic [15:0]       push_data_s;
    logic [NCHANS-1:0] shift_s;
    logic              hdr_bit_s;

    // Round-robin search: first pending channel at or after the rr pointer, wrapping.
    always_comb begin
        int idx;
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        for (int i = 0; i < NCHANS; i++) begin
            idx = int'(rr_r) + i;
            if (idx >= NCHANS) begin
                idx = idx - NCHANS;
            end else begin
                idx = idx;
            end
            if (!grant_found_s && pending_r[idx]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = CW'(idx);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
        grant_s        = (state_r == ST_IDLE) && grant_found_s;
        clr_s          = '0;
        clr_s[grant_idx_s] = grant_s;
    end

    // Datapath: a bit is captured only when the word it completes can be pushed.
    always_comb begin
        full_s      = (count_r == DEPTH_C);
        pop_s       = rd && (count_r != '0);
        can_push_s  = !full_s || rd;
        cur_sout_s  = sout[chan_r];
        cur_word_s  = {wbuf_r, cur_sout_s};
        abort_s     = (state_r != ST_IDLE) && epoch[chan_r];
        last_s      = (bitcnt_r == LAST_C);
        word_done_s = (wcnt_r == 4'd15) || last_s;
        cap_s       = (state_r == ST_SHIFT) && !abort_s && (!word_done_s || can_push_s);
        push_hdr_s  = (state_r == ST_HDR) && !abort_s && can_push_s;
        push_s      = push_hdr_s || (cap_s && word_done_s);
        if (push_hdr_s) begin
            push_data_s = {8'hA5, hdr_bit_s, 1'b0, 6'(chan_r)};
        end else begin
            push_data_s = cur_word_s << (4'd15 - wcnt_r);
        end
        shift_s         = '0;
        shift_s[chan_r] = cap_s;
    end

    // Scheduler FSM, pending flags and word builder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            pending_r <= '0;
            chan_r    <= '0;
            rr_r      <= '0;
            bitcnt_r  <= '0;
            wcnt_r    <= 4'd0;
            wbuf_r    <= 15'd0;
        end else begin
            pending_r <= (pending_r & ~clr_s) | epoch;
            case (state_r)
                ST_IDLE: begin
                    if (grant_s) begin
                        chan_r  <= grant_idx_s;
                        state_r <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (abort_s) begin
                        state_r <= ST_IDLE;
                    end else if (push_hdr_s) begin
                        state_r  <= ST_SHIFT;
                        bitcnt_r <= '0;
                        wcnt_r   <= 4'd0;
                        wbuf_r   <= 15'd0;
                    end
                end
                ST_SHIFT: begin
                    if (abort_s) begin
                        state_r <= ST_IDLE;
                    end else if (cap_s) begin
                        bitcnt_r <= bitcnt_r + BW'(1);
                        wbuf_r   <= cur_word_s[14:0];
                        wcnt_r   <= word_done_s ? 4'd0 : wcnt_r + 4'd1;
                        if (last_s) begin
                            state_r <= ST_IDLE;
                            rr_r    <= (chan_r == MAXCH_C) ? '0 : chan_r + CW'(1);
                        end
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // FIFO pointers and occupancy; a push into a full FIFO only happens alongside a pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (push_s) wptr_r <= wptr_r + AW'(1);
            if (pop_s)  rptr_r <= rptr_r + AW'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNTW'(1);
                2'b01:   count_r <= count_r - CNTW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (push_s) mem_r[wptr_r] <= push_data_s;
    end

`ifdef GPS_READOUT_OVR_EN
    logic [NCHANS-1:0] ovr_r;
    logic [NCHANS-1:0] ovr_set_s;
    logic [NCHANS-1:0] ovr_nxt_s;
    logic              hdr_ovr_r;

    // Overrun sources: re-epoch of a still-pending channel, or an aborted frame.
    always_comb begin
        ovr_set_s         = epoch & pending_r;
        ovr_set_s[chan_r] = ovr_set_s[chan_r] | abort_s;
        ovr_nxt_s         = (ovr_r & ~ovr_clr) | ovr_set_s;
    end

    // Sticky flags; the header bit is frozen at grant time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr_r     <= '0;
            hdr_ovr_r <= 1'b0;
        end else begin
            ovr_r <= ovr_nxt_s;
            if (grant_s) hdr_ovr_r <= ovr_nxt_s[grant_idx_s];
        end
    end

    assign ovr       = ovr_r;
    assign hdr_bit_s = hdr_ovr_r;
`else
    assign hdr_bit_s = 1'b0;
`endif

    assign shift = shift_s;
    assign rdata = (count_r == '0) ? 16'h0000 : mem_r[rptr_r];
    assign empty = (count_r == '0);
    assign count = count_r;
    assign busy  = (state_r != ST_IDLE);

endmodule
